// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared pipeline-control types and constants
package core_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } hazard_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - clearable up-counter that sticks at all-ones
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - load-use bubbles, redirect flushes and data-memory freeze with watchdog
module hazard_controller
    import core_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] IFIDrs1,
    input  logic [REG_IDX_W-1:0] IFIDrs2,
    input  logic                 ID_uses_rs1,
    input  logic                 ID_uses_rs2,
    input  logic                 IDEX_MemRead,
    input  logic [REG_IDX_W-1:0] IDEXrd,
    input  logic                 EX_branch_taken,
    input  logic                 EXMEM_MemAccess,
    input  logic                 dmem_ready,
    output logic                 PC_write,
    output logic                 IFID_write,
    output logic                 IFID_flush,
    output logic                 IDEX_write,
    output logic                 IDEX_flush,
    output logic                 EXMEM_write,
    output logic                 MEMWB_flush,
    output logic                 mem_timeout,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     flush_count
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(MEM_TIMEOUT - 1);
    localparam logic [15:0] WAIT_ONE    = 16'd1;

    hazard_state_t state;
    logic [15:0]   wait_cnt;

    logic in_halt;
    logic mem_wait;
    logic redirect;
    logic rs_match;
    logic load_use;

    assign in_halt  = (state == HALT);
    assign mem_wait = !in_halt && EXMEM_MemAccess && !dmem_ready;
    // A frozen EX keeps its redirect pending; it fires on the release cycle.
    assign redirect = !in_halt && !mem_wait && EX_branch_taken;
    assign rs_match = (ID_uses_rs1 && (IDEXrd == IFIDrs1)) ||
                      (ID_uses_rs2 && (IDEXrd == IFIDrs2));
    assign load_use = !in_halt && !mem_wait && !redirect &&
                      IDEX_MemRead && (IDEXrd != ZERO_REG) && rs_match;

    always_comb begin
        PC_write    = 1'b1;
        IFID_write  = 1'b1;
        IFID_flush  = 1'b0;
        IDEX_write  = 1'b1;
        IDEX_flush  = 1'b0;
        EXMEM_write = 1'b1;
        MEMWB_flush = 1'b0;
        if (rst) begin
            PC_write    = 1'b0;
            IFID_write  = 1'b0;
            IFID_flush  = 1'b1;
            IDEX_write  = 1'b0;
            IDEX_flush  = 1'b1;
            EXMEM_write = 1'b0;
            MEMWB_flush = 1'b1;
        end else if (in_halt || mem_wait) begin
            PC_write    = 1'b0;
            IFID_write  = 1'b0;
            IDEX_write  = 1'b0;
            EXMEM_write = 1'b0;
            MEMWB_flush = 1'b1;
        end else if (redirect) begin
            IFID_flush  = 1'b1;
            IDEX_flush  = 1'b1;
        end else if (load_use) begin
            PC_write    = 1'b0;
            IFID_write  = 1'b0;
            IDEX_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_wait) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_ONE;
                    end
                end
                MEM_WAIT: begin
                    if (!mem_wait) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == TIMEOUT_CNT) begin
                        state       <= HALT;
                        mem_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_ONE;
                    end
                end
                HALT: begin
                    mem_timeout <= 1'b1;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (!PC_write),
        .count (stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (redirect),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - randomized bench against a rule-level model for two parameter sets
module tb_hazard_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] IFIDrs1, IFIDrs2, IDEXrd;
    logic       ID_uses_rs1, ID_uses_rs2, IDEX_MemRead;
    logic       EX_branch_taken, EXMEM_MemAccess, dmem_ready;

    logic        a_pc_w, a_ifid_w, a_ifid_f, a_idex_w, a_idex_f, a_exmem_w, a_memwb_f, a_mt;
    logic [31:0] a_stall, a_flush;
    logic        b_pc_w, b_ifid_w, b_ifid_f, b_idex_w, b_idex_f, b_exmem_w, b_memwb_f, b_mt;
    logic [3:0]  b_stall, b_flush;

    int checks = 0;
    int errors = 0;

    hazard_controller #(.MEM_TIMEOUT(4), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst),
        .IFIDrs1(IFIDrs1), .IFIDrs2(IFIDrs2),
        .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
        .IDEX_MemRead(IDEX_MemRead), .IDEXrd(IDEXrd),
        .EX_branch_taken(EX_branch_taken),
        .EXMEM_MemAccess(EXMEM_MemAccess), .dmem_ready(dmem_ready),
        .PC_write(a_pc_w), .IFID_write(a_ifid_w), .IFID_flush(a_ifid_f),
        .IDEX_write(a_idex_w), .IDEX_flush(a_idex_f), .EXMEM_write(a_exmem_w),
        .MEMWB_flush(a_memwb_f), .mem_timeout(a_mt),
        .stall_cycles(a_stall), .flush_count(a_flush)
    );

    hazard_controller #(.MEM_TIMEOUT(64), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst),
        .IFIDrs1(IFIDrs1), .IFIDrs2(IFIDrs2),
        .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
        .IDEX_MemRead(IDEX_MemRead), .IDEXrd(IDEXrd),
        .EX_branch_taken(EX_branch_taken),
        .EXMEM_MemAccess(EXMEM_MemAccess), .dmem_ready(dmem_ready),
        .PC_write(b_pc_w), .IFID_write(b_ifid_w), .IFID_flush(b_ifid_f),
        .IDEX_write(b_idex_w), .IDEX_flush(b_idex_f), .EXMEM_write(b_exmem_w),
        .MEMWB_flush(b_memwb_f), .mem_timeout(b_mt),
        .stall_cycles(b_stall), .flush_count(b_flush)
    );

    // Model: per instance, a halted flag, the run length of consecutive memory
    // waits, and unbounded event counts clamped to the counter width on compare.
    int     m_limit [2] = '{4, 64};
    longint m_cap   [2] = '{64'hFFFF_FFFF, 64'd15};
    bit     m_halt  [2];
    int     m_wait  [2];
    longint m_stall [2];
    longint m_flush [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [6:0] e, act;
            logic       act_mt;
            longint     act_st, act_fl, e_st, e_fl;
            bit         mw, lu;
            mw = EXMEM_MemAccess && !dmem_ready;
            lu = IDEX_MemRead && (IDEXrd != 5'd0) &&
                 ((ID_uses_rs1 && IDEXrd == IFIDrs1) || (ID_uses_rs2 && IDEXrd == IFIDrs2));
            // bit order: PC_write IFID_write IFID_flush IDEX_write IDEX_flush EXMEM_write MEMWB_flush
            if (rst)                 e = 7'b0010101;
            else if (m_halt[i] || mw) e = 7'b0000001;
            else if (EX_branch_taken) e = 7'b1111110;
            else if (lu)             e = 7'b0001110;
            else                     e = 7'b1101010;
            if (i == 0) begin
                act    = {a_pc_w, a_ifid_w, a_ifid_f, a_idex_w, a_idex_f, a_exmem_w, a_memwb_f};
                act_mt = a_mt;
                act_st = longint'(a_stall);
                act_fl = longint'(a_flush);
            end else begin
                act    = {b_pc_w, b_ifid_w, b_ifid_f, b_idex_w, b_idex_f, b_exmem_w, b_memwb_f};
                act_mt = b_mt;
                act_st = longint'(b_stall);
                act_fl = longint'(b_flush);
            end
            e_st = (m_stall[i] > m_cap[i]) ? m_cap[i] : m_stall[i];
            e_fl = (m_flush[i] > m_cap[i]) ? m_cap[i] : m_flush[i];
            checks += 4;
            if (act !== e) begin
                errors++;
                $display("FAIL ctl[%0d] t=%0t got=%b want=%b", i, $time, act, e);
            end
            if (act_mt !== m_halt[i]) begin
                errors++;
                $display("FAIL mem_timeout[%0d] t=%0t got=%b want=%b", i, $time, act_mt, m_halt[i]);
            end
            if (act_st != e_st) begin
                errors++;
                $display("FAIL stall_cycles[%0d] t=%0t got=%0d want=%0d", i, $time, act_st, e_st);
            end
            if (act_fl != e_fl) begin
                errors++;
                $display("FAIL flush_count[%0d] t=%0t got=%0d want=%0d", i, $time, act_fl, e_fl);
            end
            if (rst) begin
                m_halt[i]  = 1'b0;
                m_wait[i]  = 0;
                m_stall[i] = 0;
                m_flush[i] = 0;
            end else begin
                if (!e[6]) m_stall[i]++;
                if (!m_halt[i]) begin
                    if (mw) begin
                        m_wait[i]++;
                        if (m_wait[i] == m_limit[i]) m_halt[i] = 1'b1;
                    end else begin
                        m_wait[i] = 0;
                        if (EX_branch_taken) m_flush[i]++;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic set_idle();
        IFIDrs1 = 5'd1; IFIDrs2 = 5'd2; IDEXrd = 5'd3;
        ID_uses_rs1 = 1'b0; ID_uses_rs2 = 1'b0; IDEX_MemRead = 1'b0;
        EX_branch_taken = 1'b0; EXMEM_MemAccess = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic set_load_use();
        set_idle();
        IDEX_MemRead = 1'b1; IDEXrd = 5'd5; IFIDrs1 = 5'd5; ID_uses_rs1 = 1'b1;
    endtask

    task automatic do_reset();
        next_cycle();
        rst = 1'b1;
        set_idle();
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        settle();
        chk("rst_pc_write", a_pc_w, 0);
        chk("rst_ifid_flush", a_ifid_f, 1);
        chk("rst_memwb_flush", a_memwb_f, 1);
        next_cycle(); rst = 1'b0; settle();
        chk("reset_stall", a_stall, 0);
        chk("reset_flush", a_flush, 0);
        chk("reset_mt", a_mt, 0);
        chk("idle_pc_write", a_pc_w, 1);

        next_cycle(); set_load_use(); settle();
        chk("lu_pc_write", a_pc_w, 0);
        chk("lu_ifid_write", a_ifid_w, 0);
        chk("lu_idex_flush", a_idex_f, 1);
        next_cycle(); set_idle(); settle();
        chk("lu_after_pc_write", a_pc_w, 1);
        chk("lu_stall", a_stall, 1);
        next_cycle(); IDEX_MemRead = 1'b1; IDEXrd = 5'd0; IFIDrs1 = 5'd0; ID_uses_rs1 = 1'b1; settle();
        chk("x0_no_stall", a_pc_w, 1);
        next_cycle(); IDEXrd = 5'd7; IFIDrs1 = 5'd3; IFIDrs2 = 5'd7; ID_uses_rs2 = 1'b0; settle();
        chk("unused_rs2_no_stall", a_pc_w, 1);
        next_cycle(); set_idle(); settle();
        chk("negatives_stall", a_stall, 1);

        do_reset();
        next_cycle(); set_load_use(); EX_branch_taken = 1'b1; settle();
        chk("redir_ifid_flush", a_ifid_f, 1);
        chk("redir_idex_flush", a_idex_f, 1);
        chk("redir_pc_write", a_pc_w, 1);
        next_cycle(); set_idle(); settle();
        chk("redir_flush_count", a_flush, 1);
        chk("redir_stall", a_stall, 0);

        do_reset();
        for (int k = 0; k < 3; k++) begin
            next_cycle(); EXMEM_MemAccess = 1'b1; dmem_ready = 1'b0; EX_branch_taken = 1'b1; settle();
            chk("wait_memwb_flush", a_memwb_f, 1);
            chk("wait_ifid_flush", a_ifid_f, 0);
            chk("wait_pc_write", a_pc_w, 0);
        end
        next_cycle(); dmem_ready = 1'b1; settle();
        chk("release_ifid_flush", a_ifid_f, 1);
        chk("release_pc_write", a_pc_w, 1);
        chk("release_memwb_flush", a_memwb_f, 0);
        next_cycle(); set_idle(); settle();
        chk("wait_stall", a_stall, 3);
        chk("wait_flush_count", a_flush, 1);

        do_reset();
        for (int k = 1; k <= 6; k++) begin
            next_cycle(); EXMEM_MemAccess = 1'b1; dmem_ready = 1'b0; settle();
            chk("timeout_flag", a_mt, (k >= 5) ? 1 : 0);
        end
        next_cycle(); dmem_ready = 1'b1; EX_branch_taken = 1'b1; settle();
        chk("halt_pc_write", a_pc_w, 0);
        chk("halt_ifid_flush", a_ifid_f, 0);
        chk("halt_flag_held", a_mt, 1);
        next_cycle(); rst = 1'b1; set_idle();
        next_cycle(); rst = 1'b0; settle();
        chk("halt_rst_mt", a_mt, 0);
        chk("halt_rst_stall", a_stall, 0);
        chk("halt_rst_flush", a_flush, 0);
        chk("halt_rst_pc_write", a_pc_w, 1);

        do_reset();
        for (int k = 0; k < 20; k++) begin
            next_cycle(); set_load_use(); settle();
        end
        next_cycle(); set_idle(); settle();
        chk("sat_stall_w4", b_stall, 15);
        chk("sat_stall_w32", a_stall, 20);

        for (int k = 0; k < 3000; k++) begin
            next_cycle();
            rst             = ($urandom_range(99) < 2);
            IFIDrs1         = 5'($urandom_range(3));
            IFIDrs2         = 5'($urandom_range(3));
            IDEXrd          = 5'($urandom_range(3));
            ID_uses_rs1     = 1'($urandom_range(1));
            ID_uses_rs2     = 1'($urandom_range(1));
            IDEX_MemRead    = ($urandom_range(99) < 40);
            EX_branch_taken = ($urandom_range(99) < 20);
            EXMEM_MemAccess = ($urandom_range(99) < 40);
            dmem_ready      = 1'($urandom_range(1));
        end
        next_cycle(); rst = 1'b0; set_idle();
        settle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
